// File: rtl/serial_frame_sequencer_if.sv
// Handshake between the frame sequencer and the serial read buffer it drives:
// start/count/reset go to the buffer, done/data come back.
interface serial_frame_sequencer_if #(
    parameter int BUF_SIZE = 8
);
    localparam int RC_W = $clog2(BUF_SIZE + 1);

    logic                buf_start;
    logic [RC_W-1:0]     buf_read_count;
    logic                buf_rst;
    logic                buf_done;
    logic [BUF_SIZE-1:0] buf_data;

    modport master (
        output buf_start, buf_read_count, buf_rst,
        input  buf_done, buf_data
    );

    modport slave (
        input  buf_start, buf_read_count, buf_rst,
        output buf_done, buf_data
    );
endinterface

// File: rtl/serial_frame_sequencer.sv
// Receives one framed transaction (header word, then N payload words) per rising
// edge of frame_active by sequencing start/wait cycles on the serial read buffer.
module serial_frame_sequencer #(
    parameter int BUF_SIZE = 8,
    parameter int HDR_BITS = 8,
    parameter int LEN_BITS = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     frame_active,
    serial_frame_sequencer_if.master buf_if,
    output logic [HDR_BITS-1:0]      hdr_out,
    output logic                     hdr_valid,
    output logic [BUF_SIZE-1:0]      data_out,
    output logic                     data_valid,
    output logic                     frame_done,
    output logic                     frame_err,
    output logic                     busy
);
    localparam int RC_W = $clog2(BUF_SIZE + 1);
    localparam logic [RC_W-1:0]     HDR_CNT = RC_W'(HDR_BITS);
    localparam logic [RC_W-1:0]     PAY_CNT = RC_W'(BUF_SIZE);
    localparam logic [LEN_BITS-1:0] REM_ONE = LEN_BITS'(1);

    typedef enum logic [3:0] {
        IDLE, H_START, H_GUARD, H_WAIT, P_START, P_GUARD, P_WAIT, FINISH, ABORT
    } state_t;

    state_t              state_q, state_d;
    logic                fa_prev_q;
    logic [LEN_BITS-1:0] rem_q, rem_d;
    logic [HDR_BITS-1:0] hdr_q, hdr_d;
    logic [BUF_SIZE-1:0] data_q, data_d;
    logic [RC_W-1:0]     rc_q, rc_d;
    logic                start_q, start_d;
    logic                hdr_valid_q, hdr_valid_d;
    logic                data_valid_q, data_valid_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        rem_d        = rem_q;
        hdr_d        = hdr_q;
        data_d       = data_q;
        hdr_valid_d  = 1'b0;
        data_valid_d = 1'b0;

        case (state_q)
            IDLE:    if (frame_active && !fa_prev_q) state_d = H_START;
            H_START: state_d = frame_active ? H_GUARD : ABORT;
            // The buffer still shows the previous done during the guard cycle.
            H_GUARD: state_d = frame_active ? H_WAIT : ABORT;
            H_WAIT: begin
                if (buf_if.buf_done) begin
                    hdr_d       = buf_if.buf_data[HDR_BITS-1:0];
                    hdr_valid_d = 1'b1;
                    rem_d       = buf_if.buf_data[LEN_BITS-1:0];
                    if (buf_if.buf_data[LEN_BITS-1:0] == '0) state_d = FINISH;
                    else                                      state_d = frame_active ? P_START : ABORT;
                end else if (!frame_active) begin
                    state_d = ABORT;
                end
            end
            P_START: state_d = frame_active ? P_GUARD : ABORT;
            P_GUARD: state_d = frame_active ? P_WAIT : ABORT;
            P_WAIT: begin
                if (buf_if.buf_done) begin
                    data_d       = buf_if.buf_data;
                    data_valid_d = 1'b1;
                    rem_d        = rem_q - REM_ONE;
                    // A capture that completes the frame wins over a simultaneous abort.
                    if (rem_q == REM_ONE) state_d = FINISH;
                    else                  state_d = frame_active ? P_START : ABORT;
                end else if (!frame_active) begin
                    state_d = ABORT;
                end
            end
            FINISH:  state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        start_d = (state_d == H_START) || (state_d == P_START);
        rc_d    = (state_d == H_START) ? HDR_CNT :
                  (state_d == P_START) ? PAY_CNT : '0;
        err_d   = (state_d == ABORT);
        done_d  = (state_q == FINISH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q      <= IDLE;
            // Treat the line as already high so a level held through reset is not an edge.
            fa_prev_q    <= 1'b1;
            rem_q        <= '0;
            hdr_q        <= '0;
            data_q       <= '0;
            rc_q         <= '0;
            start_q      <= 1'b0;
            hdr_valid_q  <= 1'b0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fa_prev_q    <= frame_active;
            rem_q        <= rem_d;
            hdr_q        <= hdr_d;
            data_q       <= data_d;
            rc_q         <= rc_d;
            start_q      <= start_d;
            hdr_valid_q  <= hdr_valid_d;
            data_valid_q <= data_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign buf_if.buf_start      = start_q;
    assign buf_if.buf_read_count = rc_q;
    assign buf_if.buf_rst        = rst | err_q;
    assign hdr_out               = hdr_q;
    assign hdr_valid             = hdr_valid_q;
    assign data_out              = data_q;
    assign data_valid            = data_valid_q;
    assign frame_done            = done_q;
    assign frame_err             = err_q;
    assign busy                  = busy_q;
endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Directed bench for serial_frame_sequencer: a default instance plus a narrow
// parameter override, each fed by a simple buffer model driven from the test tasks.
module tb_serial_frame_sequencer;
    logic clk = 1'b0;
    logic rst, fa, fa2;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_frame_sequencer_if #(.BUF_SIZE(8)) bif ();
    serial_frame_sequencer_if #(.BUF_SIZE(6)) bif2 ();

    logic [7:0] hdr_out, data_out;
    logic       hdr_valid, data_valid, frame_done, frame_err, busy;
    logic [3:0] hdr_out2;
    logic [5:0] data_out2;
    logic       hdr_valid2, data_valid2, frame_done2, frame_err2, busy2;

    serial_frame_sequencer dut (
        .sys_clk(clk), .rst(rst), .frame_active(fa), .buf_if(bif),
        .hdr_out(hdr_out), .hdr_valid(hdr_valid), .data_out(data_out),
        .data_valid(data_valid), .frame_done(frame_done), .frame_err(frame_err),
        .busy(busy)
    );

    serial_frame_sequencer #(.BUF_SIZE(6), .HDR_BITS(4), .LEN_BITS(2)) dut2 (
        .sys_clk(clk), .rst(rst), .frame_active(fa2), .buf_if(bif2),
        .hdr_out(hdr_out2), .hdr_valid(hdr_valid2), .data_out(data_out2),
        .data_valid(data_valid2), .frame_done(frame_done2), .frame_err(frame_err2),
        .busy(busy2)
    );

    // Pulse counters for the default instance, sampled just after each rising edge.
    int n_hdr = 0, n_data = 0, n_done = 0, n_err = 0, n_start = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (hdr_valid)     n_hdr++;
        if (data_valid)    n_data++;
        if (frame_done)    n_done++;
        if (frame_err)     n_err++;
        if (bif.buf_start) n_start++;
    end

    // Buffer model: wait for start, keep done high through the guard cycle, then
    // drop it for the read and raise it with the word; optionally drop frame_active
    // in the same cycle as the final done.
    task automatic serve(input logic [7:0] word, input bit drop, output logic [3:0] rc);
        int t = 0;
        rc = '0;
        while (bif.buf_start !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bif.buf_start !== 1'b1) begin
            failures++;
            $display("FAIL serve_start: buf_start=%b, required 1 within 40 cycles", bif.buf_start);
        end else begin
            rc = bif.buf_read_count;
            @(negedge clk);
            @(negedge clk);
            bif.buf_done = 1'b0;
            repeat (int'(rc) - 1) @(negedge clk);
            bif.buf_done = 1'b1;
            bif.buf_data = word;
            if (drop) fa = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; fa = 1'b1; fa2 = 1'b0;
        bif.buf_done = 1'b1;  bif.buf_data = '0;
        bif2.buf_done = 1'b1; bif2.buf_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, hdr_valid, data_valid, frame_done, frame_err, bif.buf_start} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: busy/hv/dv/done/err/start=%b, required 000000",
                     {busy, hdr_valid, data_valid, frame_done, frame_err, bif.buf_start});
        end
        checks++;
        if (bif.buf_read_count !== 4'd0 || hdr_out !== 8'h00 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_values: rc=%0d hdr=%h data=%h, required 0 00 00",
                     bif.buf_read_count, hdr_out, data_out);
        end
        checks++;
        if (bif.buf_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_buf_rst: buf_rst=%b, required 1", bif.buf_rst);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bif.buf_start !== 1'b0 || bif.buf_rst !== 1'b0) begin
            failures++;
            $display("FAIL level_not_edge: busy=%b start=%b buf_rst=%b, required 0 0 0",
                     busy, bif.buf_start, bif.buf_rst);
        end
        fa = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal_frame;
        logic [7:0] pay [3];
        logic [3:0] rc;
        int e0 = n_err, d0 = n_data;
        pay[0] = 8'h3A; pay[1] = 8'hC5; pay[2] = 8'h0F;
        fa = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.buf_start !== 1'b1 || bif.buf_read_count !== 4'd8 || busy !== 1'b1) begin
            failures++;
            $display("FAIL frame_start: start=%b rc=%0d busy=%b, required 1 8 1",
                     bif.buf_start, bif.buf_read_count, busy);
        end
        serve(8'h03, 1'b0, rc);
        @(negedge clk);
        checks++;
        if (hdr_valid !== 1'b1 || hdr_out !== 8'h03 || bif.buf_start !== 1'b1) begin
            failures++;
            $display("FAIL hdr_capture: hv=%b hdr=%h start=%b, required 1 03 1",
                     hdr_valid, hdr_out, bif.buf_start);
        end
        for (int i = 0; i < 3; i++) begin
            serve(pay[i], 1'b0, rc);
            @(negedge clk);
            checks++;
            if (data_valid !== 1'b1 || data_out !== pay[i] || rc !== 4'd8 || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL payload_%0d: dv=%b data=%h rc=%0d done=%b, required 1 %h 8 0",
                         i, data_valid, data_out, rc, frame_done, pay[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || data_valid !== 1'b0) begin
            failures++;
            $display("FAIL normal_done: done=%b dv=%b, required 1 0", frame_done, data_valid);
        end
        fa = 1'b0;
        @(negedge clk);
        checks++;
        if (n_err != e0 || n_data - d0 != 3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL normal_totals: errs=%0d words=%0d busy=%b, required 0 3 0",
                     n_err - e0, n_data - d0, busy);
        end
    endtask

    task automatic test_zero_length;
        logic [3:0] rc;
        int s0 = n_start, d0 = n_data;
        fa = 1'b1;
        @(negedge clk);
        serve(8'hF0, 1'b0, rc);
        @(negedge clk);
        checks++;
        if (hdr_valid !== 1'b1 || hdr_out !== 8'hF0 || bif.buf_start !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL zero_hdr: hv=%b hdr=%h start=%b done=%b, required 1 f0 0 0",
                     hdr_valid, hdr_out, bif.buf_start, frame_done);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1) begin
            failures++;
            $display("FAIL zero_done: done=%b, required 1", frame_done);
        end
        fa = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (n_start - s0 != 1 || n_data != d0) begin
            failures++;
            $display("FAIL zero_starts: starts=%0d words=%0d, required 1 0", n_start - s0, n_data - d0);
        end
    endtask

    task automatic test_abort_midword;
        logic [3:0] rc;
        int d0 = n_data;
        fa = 1'b1;
        @(negedge clk);
        serve(8'h02, 1'b0, rc);
        @(negedge clk);
        checks++;
        if (hdr_valid !== 1'b1 || hdr_out !== 8'h02 || bif.buf_start !== 1'b1) begin
            failures++;
            $display("FAIL abort_hdr: hv=%b hdr=%h start=%b, required 1 02 1",
                     hdr_valid, hdr_out, bif.buf_start);
        end
        @(negedge clk);
        @(negedge clk);
        bif.buf_done = 1'b0;
        repeat (4) @(negedge clk);
        fa = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b1 || bif.buf_rst !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pulse: err=%b buf_rst=%b busy=%b, required 1 1 1",
                     frame_err, bif.buf_rst, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_err !== 1'b0 || bif.buf_rst !== 1'b0) begin
            failures++;
            $display("FAIL abort_after: busy=%b err=%b buf_rst=%b, required 0 0 0",
                     busy, frame_err, bif.buf_rst);
        end
        checks++;
        if (n_data != d0 || data_out !== 8'h0F) begin
            failures++;
            $display("FAIL abort_data: words=%0d data=%h, required 0 0f", n_data - d0, data_out);
        end
        bif.buf_done = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_same_cycle;
        logic [3:0] rc;
        int e0 = n_err, c0 = n_done;
        fa = 1'b1;
        @(negedge clk);
        serve(8'h02, 1'b0, rc);
        @(negedge clk);
        serve(8'h11, 1'b0, rc);
        @(negedge clk);
        serve(8'h99, 1'b1, rc);
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h99 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL final_coincident: dv=%b data=%h err=%b, required 1 99 0",
                     data_valid, data_out, frame_err);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL final_coincident_done: done=%b err=%b, required 1 0", frame_done, frame_err);
        end
        @(negedge clk);
        checks++;
        if (n_err != e0 || n_done - c0 != 1) begin
            failures++;
            $display("FAIL final_coincident_totals: errs=%0d dones=%0d, required 0 1", n_err - e0, n_done - c0);
        end
        e0 = n_err; c0 = n_done;
        fa = 1'b1;
        @(negedge clk);
        serve(8'h02, 1'b0, rc);
        @(negedge clk);
        serve(8'h66, 1'b1, rc);
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h66) begin
            failures++;
            $display("FAIL nonfinal_coincident: dv=%b data=%h, required 1 66", data_valid, data_out);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_err - e0 != 1 || n_done != c0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL nonfinal_totals: errs=%0d dones=%0d busy=%b, required 1 0 0",
                     n_err - e0, n_done - c0, busy);
        end
    endtask

    task automatic test_reset_in_wait;
        logic [3:0] rc;
        fa = 1'b1;
        @(negedge clk);
        serve(8'h01, 1'b0, rc);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bif.buf_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bif.buf_rst !== 1'b1) begin
            failures++;
            $display("FAIL rst_buf_rst: buf_rst=%b, required 1", bif.buf_rst);
        end
        @(negedge clk);
        checks++;
        if ({busy, bif.buf_start, hdr_valid, data_valid, frame_done, frame_err} !== 6'b0 ||
            bif.buf_read_count !== 4'd0 || hdr_out !== 8'h00 || data_out !== 8'h00 || bif.buf_rst !== 1'b1) begin
            failures++;
            $display("FAIL rst_midframe: flags=%b rc=%0d hdr=%h data=%h buf_rst=%b, required 000000 0 00 00 1",
                     {busy, bif.buf_start, hdr_valid, data_valid, frame_done, frame_err},
                     bif.buf_read_count, hdr_out, data_out, bif.buf_rst);
        end
        rst = 1'b0; fa = 1'b0; bif.buf_done = 1'b1;
        repeat (2) @(negedge clk);
        fa = 1'b1;
        @(negedge clk);
        serve(8'h01, 1'b0, rc);
        @(negedge clk);
        checks++;
        if (hdr_valid !== 1'b1 || hdr_out !== 8'h01) begin
            failures++;
            $display("FAIL rst_next_hdr: hv=%b hdr=%h, required 1 01", hdr_valid, hdr_out);
        end
        serve(8'h52, 1'b0, rc);
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h52) begin
            failures++;
            $display("FAIL rst_next_data: dv=%b data=%h, required 1 52", data_valid, data_out);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1) begin
            failures++;
            $display("FAIL rst_next_done: done=%b, required 1", frame_done);
        end
        fa = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_param_override;
        fa2 = 1'b1;
        @(negedge clk);
        checks++;
        if (bif2.buf_start !== 1'b1 || bif2.buf_read_count !== 3'd4) begin
            failures++;
            $display("FAIL p_hdr_start: start=%b rc=%0d, required 1 4", bif2.buf_start, bif2.buf_read_count);
        end
        @(negedge clk);
        @(negedge clk);
        bif2.buf_done = 1'b0;
        repeat (3) @(negedge clk);
        bif2.buf_done = 1'b1;
        bif2.buf_data = 6'h01;
        @(negedge clk);
        checks++;
        if (hdr_valid2 !== 1'b1 || hdr_out2 !== 4'h1 || bif2.buf_start !== 1'b1 || bif2.buf_read_count !== 3'd6) begin
            failures++;
            $display("FAIL p_hdr: hv=%b hdr=%h start=%b rc=%0d, required 1 1 1 6",
                     hdr_valid2, hdr_out2, bif2.buf_start, bif2.buf_read_count);
        end
        @(negedge clk);
        @(negedge clk);
        bif2.buf_done = 1'b0;
        repeat (5) @(negedge clk);
        bif2.buf_done = 1'b1;
        bif2.buf_data = 6'o52;
        @(negedge clk);
        checks++;
        if (data_valid2 !== 1'b1 || data_out2 !== 6'o52) begin
            failures++;
            $display("FAIL p_data: dv=%b data=%o, required 1 52", data_valid2, data_out2);
        end
        @(negedge clk);
        checks++;
        if (frame_done2 !== 1'b1 || frame_err2 !== 1'b0) begin
            failures++;
            $display("FAIL p_done: done=%b err=%b, required 1 0", frame_done2, frame_err2);
        end
        fa2 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy2 !== 1'b0) begin
            failures++;
            $display("FAIL p_idle: busy=%b, required 0", busy2);
        end
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_zero_length();
        test_abort_midword();
        test_same_cycle();
        test_reset_in_wait();
        test_param_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/serial_frame_sequencer.md
# serial_frame_sequencer

Controller that drives a serial read buffer (the `start` / `read_count` / `done_sig` / `data_out` primitive) to receive one framed transaction per assertion of a frame-active strobe. The frame is a header word of `HDR_BITS` followed by N payload words of `BUF_SIZE` bits. N is the low `LEN_BITS` of the header. The block sits between the bus front end (chip-select and edge detectors) and the MITM packet logic. It emits the header, each payload word with a valid strobe, and a done or error pulse per frame.

## Interface
- `BUF_SIZE`, 8, payload word width; must equal the attached buffer's `BUF_SIZE`.
- `HDR_BITS`, 8, header width; 1..`BUF_SIZE`.
- `LEN_BITS`, 4, header LSBs holding the payload word count; 1..`HDR_BITS`.
- `RC_W`, `$clog2(BUF_SIZE+1)`, width of the read count (derived, not overridable).

- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `frame_active`  in  1  synchronized, active-high frame window (e.g. inverted CS).
- `buf_done`  in  1  buffer `done_sig` (level; high while the buffer is idle with data valid).
- `buf_data`  in  `BUF_SIZE`  buffer `data_out`.
- `buf_start`  out  1  one-cycle start pulse to the buffer.
- `buf_read_count`  out  `RC_W`  bit count for the buffer; stable while `buf_start` is high.
- `buf_rst`  out  1  buffer reset; equals `rst` OR the registered abort pulse.
- `hdr_out`  out  `HDR_BITS`  last captured header.
- `hdr_valid`  out  1  one-cycle pulse when `hdr_out` updates.
- `data_out`  out  `BUF_SIZE`  last captured payload word.
- `data_valid`  out  1  one-cycle pulse when `data_out` updates.
- `frame_done`  out  1  one-cycle pulse when a frame completes normally.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, H_START, H_GUARD, H_WAIT, P_START, P_GUARD, P_WAIT, FINISH, ABORT.
- **IDLE:** a rising edge of `frame_active` (high now, low the previous cycle) goes to H_START.
  - A level already high out of reset is not an edge.
- **H_START:** `buf_start`=1 and `buf_read_count`=`HDR_BITS`. Next state is H_GUARD.
- **H_GUARD:** `buf_done` is ignored here, because the buffer drops `done_sig` one cycle after sampling start. Next state is H_WAIT.
- **H_WAIT:** on `buf_done`=1:
  - `hdr_out` <= `buf_data[HDR_BITS-1:0]`, `hdr_valid` pulses.
  - The remaining counter is loaded with `buf_data[LEN_BITS-1:0]`.
  - If the count is 0, go to FINISH; otherwise go to P_START.
- **P_START / P_GUARD / P_WAIT:** same pattern as the header, with `buf_read_count`=`BUF_SIZE`. On done in P_WAIT:
  - `data_out` <= `buf_data` and `data_valid` pulses.
  - The remaining counter decrements. At 0 go to FINISH, else go to P_START.
- **FINISH:** `frame_done`=1 for one cycle, then IDLE.
- **ABORT:** `frame_err`=1 and the internal abort pulse=1 (so `buf_rst`=1) for one cycle, then IDLE.
- **Abort rule:** in H_START through P_WAIT, `frame_active`=0 forces ABORT.
  - Exception: in H_WAIT or P_WAIT with `buf_done`=1 in the same cycle, the capture happens first (the `hdr_valid`/`data_valid` pulse is emitted).
  - If that capture completes the frame, go to FINISH (no error). Otherwise go to ABORT.
- **New frames:** `frame_active` edges while busy are ignored. A new frame needs a fresh rising edge seen in IDLE.
- **Remaining counter:** `LEN_BITS` wide, with no wrap. The maximum frame is 2^`LEN_BITS`−1 payload words.
- **Reset:** `rst` wins over everything. The state returns to IDLE and `buf_rst`=1 in the same cycle.

## Timing
- **Reset values:** every registered output is 0 and the state is IDLE. `buf_read_count` is 0 whenever `buf_start` is 0.
- **Frame start:** `frame_active` rises, is sampled at edge k, and `buf_start` is high in cycle k+1.
- **Capture latency:** `buf_done` sampled at edge m gives `hdr_valid`/`data_valid` high in cycle m+1, with data already updated. The next `buf_start` is high in cycle m+1.
- **Per-word overhead:** start, then guard, then wait; at least 3 cycles beyond the buffer's own read time.
- **End of frame:** `frame_done` is high in the cycle after the last `data_valid`. For a zero-length frame it is high in the cycle after `hdr_valid`.
- **Abort:** `frame_err` and `buf_rst` are high together, one cycle after `frame_active` is sampled low. `busy` falls in the following cycle.
- **Held outputs:** `hdr_out` and `data_out` hold their values until the next capture. Abort and reset clear them only on `rst`.

## Test plan
- **Header 8'h03 + payload 8'h3A, 8'hC5, 8'h0F:** `frame_active` high, MSB-first bits → `hdr_valid` with 8'h03, then three `data_valid` pulses with 3A, C5, 0F in order, then `frame_done` 1 cycle after the last; `frame_err` stays 0.
- **Header 8'hF0 (length 0):** → `hdr_valid`, then `frame_done` the next cycle; no `buf_start` with count 8.
- **Header 8'h02, `frame_active` dropped after 4 payload bits:** → one `frame_err` + `buf_rst` pulse, no `data_valid`, `busy` low 2 cycles later, `data_out` unchanged.
- **Same-cycle completion and abort:** final `buf_done` coincident with `frame_active` falling on the last payload word → `data_valid` then `frame_done`, no `frame_err`. The same on a non-final word → `data_valid` then `frame_err`.
- **`rst` during P_WAIT:** → next cycle IDLE and all outputs 0; `buf_rst` high while `rst` is high. A following frame with header 8'h01 and data 8'h52 decodes correctly.
- **Parameter override `BUF_SIZE`=6, `HDR_BITS`=4, `LEN_BITS`=2:** header 4'h1 then 6'o52 → `buf_read_count` 4 then 6, and `data_out`=6'o52.
